// File: rtl/wt_cache_mem_mux.sv
// wt_cache_mem_mux: round-robin multiplexer of N write-through L1 clients onto one memory port
module wt_cache_mem_mux #(
  parameter int NumClients = 2,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int ClientTxIdWidth = 2,
  parameter int MaxOutstanding = 4,
  parameter int CidWidth = (NumClients > 1) ? $clog2(NumClients) : 1,
  parameter int MemTxIdWidth = CidWidth + ClientTxIdWidth
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 stall_i,
  output logic                                 busy_o,
  input  logic [NumClients-1:0]                cl_req_i,
  output logic [NumClients-1:0]                cl_ack_o,
  input  logic [NumClients*AddrWidth-1:0]      cl_addr_i,
  input  logic [NumClients*DataWidth-1:0]      cl_wdata_i,
  input  logic [NumClients-1:0]                cl_we_i,
  input  logic [NumClients*ClientTxIdWidth-1:0] cl_txid_i,
  output logic [NumClients-1:0]                cl_rtrn_vld_o,
  output logic [DataWidth-1:0]                 cl_rtrn_data_o,
  output logic [ClientTxIdWidth-1:0]           cl_rtrn_txid_o,
  output logic                                 mem_req_o,
  input  logic                                 mem_ack_i,
  output logic [AddrWidth-1:0]                 mem_addr_o,
  output logic [DataWidth-1:0]                 mem_wdata_o,
  output logic                                 mem_we_o,
  output logic [MemTxIdWidth-1:0]              mem_txid_o,
  input  logic                                 mem_rtrn_vld_i,
  input  logic [MemTxIdWidth-1:0]              mem_rtrn_txid_i,
  input  logic [DataWidth-1:0]                 mem_rtrn_data_i,
  input  logic                                 inval_valid_i,
  input  logic [AddrWidth-1:0]                 inval_addr_i,
  output logic                                 inval_ready_o,
  output logic [NumClients-1:0]                cl_inval_valid_o,
  output logic [AddrWidth-1:0]                 cl_inval_addr_o,
  input  logic [NumClients-1:0]                cl_inval_ready_i
);
  localparam int CntWidth = $clog2(MaxOutstanding + 1);
  typedef enum logic {IDLE, BCAST} inval_state_e;
  inval_state_e state_q, state_d;
  logic [NumClients-1:0] done_q, done_d, elig;
  logic [NumClients-1:0][CntWidth-1:0] cnt_q;
  logic [CidWidth-1:0] last_q, gidx, idx_hi, idx_lo, rcid;
  logic full_q, can_grant, grant, pick_hi, rtrn_ok;
  assign rcid = mem_rtrn_txid_i[MemTxIdWidth-1 -: CidWidth];
  assign can_grant = ~rst_i & ~stall_i & (~full_q | mem_ack_i);
  for (genvar g = 0; g < NumClients; g++) begin : g_cl
    assign elig[g] = cl_req_i[g] && cnt_q[g] < CntWidth'(MaxOutstanding);
    assign cl_ack_o[g] = grant && gidx == CidWidth'(g);
    // returns for idle or nonexistent clients are dropped here
    assign cl_rtrn_vld_o[g] = ~rst_i && mem_rtrn_vld_i && rcid == CidWidth'(g) && cnt_q[g] != '0;
  end
  always_comb begin
    pick_hi = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int j = NumClients - 1; j >= 0; j--) begin
      if (elig[j] && j > int'(last_q)) begin
        pick_hi = 1'b1;
        idx_hi = CidWidth'(j);
      end
      if (elig[j]) idx_lo = CidWidth'(j);
    end
  end
  assign grant = can_grant & (|elig);
  assign gidx = pick_hi ? idx_hi : idx_lo;
  assign rtrn_ok = |cl_rtrn_vld_o;
  assign cl_rtrn_data_o = rtrn_ok ? mem_rtrn_data_i : '0;
  assign cl_rtrn_txid_o = rtrn_ok ? mem_rtrn_txid_i[ClientTxIdWidth-1:0] : '0;
  assign mem_req_o = full_q;
  assign busy_o = full_q | (|cnt_q) | (state_q != IDLE);
  always_ff @(posedge clk_i)
    if (rst_i) begin
      full_q <= 1'b0;
      last_q <= CidWidth'(NumClients - 1);
      cnt_q <= '0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      mem_we_o <= 1'b0;
      mem_txid_o <= '0;
    end else begin
      if (grant) begin
        full_q <= 1'b1;
        last_q <= gidx;
      end else if (mem_ack_i) full_q <= 1'b0;
      for (int j = 0; j < NumClients; j++) begin
        if (cl_ack_o[j]) begin
          mem_addr_o <= cl_addr_i[j*AddrWidth +: AddrWidth];
          mem_wdata_o <= cl_wdata_i[j*DataWidth +: DataWidth];
          mem_we_o <= cl_we_i[j];
          mem_txid_o <= {CidWidth'(j), cl_txid_i[j*ClientTxIdWidth +: ClientTxIdWidth]};
        end
        cnt_q[j] <= cnt_q[j] + CntWidth'(cl_ack_o[j]) - CntWidth'(cl_rtrn_vld_o[j]);
      end
    end
  always_comb begin
    state_d = state_q;
    done_d = done_q;
    inval_ready_o = 1'b0;
    cl_inval_valid_o = (state_q == BCAST) ? ~done_q : '0;
    if (state_q == IDLE) begin
      if (inval_valid_i) begin
        state_d = BCAST;
        done_d = '0;
      end
    end else begin
      done_d = done_q | (cl_inval_valid_o & cl_inval_ready_i);
      if (&done_d) begin
        inval_ready_o = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      done_q <= '0;
      cl_inval_addr_o <= '0;
    end else begin
      state_q <= state_d;
      done_q <= done_d;
      if (state_q == IDLE && inval_valid_i) cl_inval_addr_o <= inval_addr_i;
    end
endmodule

// File: tb/tb_wt_cache_mem_mux.sv
// tb_wt_cache_mem_mux: directed and random checks of the mux against a cycle-level reference model
module tb_wt_cache_mem_mux;
  localparam int NC = 3;
  logic clk = 1'b0;
  logic rst, stall, mem_ack, mem_rtrn_vld, inval_valid;
  logic busy, mem_req, mem_we, inval_ready;
  logic [NC-1:0] cl_req, cl_ack, cl_we, cl_rtrn_vld, cl_inval_valid, cl_inval_ready;
  logic [NC*64-1:0] cl_addr, cl_wdata;
  logic [NC*2-1:0] cl_txid;
  logic [63:0] cl_rtrn_data, mem_addr, mem_wdata, mem_rtrn_data, inval_addr, cl_inval_addr;
  logic [1:0] cl_rtrn_txid;
  logic [3:0] mem_txid, mem_rtrn_txid;
  int n_cmp = 0, n_err = 0;
  logic m_full, m_we, m_ist;
  logic [63:0] m_addr, m_wdata, m_iaddr;
  logic [3:0] m_txid;
  logic [2:0] m_done;
  int m_cnt [NC];
  int m_last;
  always #5 clk = ~clk;
  wt_cache_mem_mux #(.NumClients(NC)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .busy_o(busy),
    .cl_req_i(cl_req), .cl_ack_o(cl_ack), .cl_addr_i(cl_addr), .cl_wdata_i(cl_wdata),
    .cl_we_i(cl_we), .cl_txid_i(cl_txid), .cl_rtrn_vld_o(cl_rtrn_vld),
    .cl_rtrn_data_o(cl_rtrn_data), .cl_rtrn_txid_o(cl_rtrn_txid),
    .mem_req_o(mem_req), .mem_ack_i(mem_ack), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_we_o(mem_we), .mem_txid_o(mem_txid), .mem_rtrn_vld_i(mem_rtrn_vld),
    .mem_rtrn_txid_i(mem_rtrn_txid), .mem_rtrn_data_i(mem_rtrn_data),
    .inval_valid_i(inval_valid), .inval_addr_i(inval_addr), .inval_ready_o(inval_ready),
    .cl_inval_valid_o(cl_inval_valid), .cl_inval_addr_o(cl_inval_addr),
    .cl_inval_ready_i(cl_inval_ready)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_full = 0; m_we = 0; m_ist = 0; m_addr = 0; m_wdata = 0; m_iaddr = 0;
    m_txid = 0; m_done = 0; m_last = NC - 1;
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
  endtask
  task automatic rnd_payload();
    for (int i = 0; i < NC * 2; i++) begin
      cl_addr[i*32 +: 32] = $urandom;
      cl_wdata[i*32 +: 32] = $urandom;
    end
    mem_rtrn_data = {$urandom, $urandom};
  endtask
  // one clock: compare combinational and registered outputs, then advance the model
  task automatic step();
    int g, rc, j;
    logic ok;
    logic [2:0] ea, er, eiv, nd;
    #1;
    g = -1;
    if ((!m_full || mem_ack) && !stall && !rst)
      for (int k = 1; k <= NC; k++) begin
        j = (m_last + k) % NC;
        if (g < 0 && cl_req[j] && m_cnt[j] < 4) g = j;
      end
    ea = 0;
    if (g >= 0) ea[g] = 1'b1;
    rc = int'(mem_rtrn_txid[3:2]);
    ok = mem_rtrn_vld && !rst && rc < NC && m_cnt[rc % NC] > 0;
    er = 0;
    if (ok) er[rc] = 1'b1;
    eiv = m_ist ? ~m_done : 3'b0;
    nd = m_done | (eiv & cl_inval_ready);
    chk("cl_ack", cl_ack, ea);
    chk("mem_req", mem_req, m_full);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_we", mem_we, m_we);
    chk("mem_txid", mem_txid, m_txid);
    chk("rtrn_vld", cl_rtrn_vld, er);
    chk("rtrn_data", cl_rtrn_data, ok ? mem_rtrn_data : 64'h0);
    chk("rtrn_txid", cl_rtrn_txid, ok ? mem_rtrn_txid[1:0] : 2'h0);
    chk("busy", busy, m_full || m_ist || (m_cnt[0] + m_cnt[1] + m_cnt[2]) > 0);
    chk("inval_valid", cl_inval_valid, eiv);
    chk("inval_ready", inval_ready, m_ist && nd == 3'b111);
    chk("inval_addr", cl_inval_addr, m_iaddr);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (g >= 0) begin
        m_full = 1; m_last = g; m_cnt[g]++;
        m_addr = cl_addr[g*64 +: 64];
        m_wdata = cl_wdata[g*64 +: 64];
        m_we = cl_we[g];
        m_txid = {2'(g), cl_txid[g*2 +: 2]};
      end else if (mem_ack) m_full = 0;
      if (ok) m_cnt[rc]--;
      if (!m_ist) begin
        if (inval_valid) begin
          m_ist = 1; m_done = 0; m_iaddr = inval_addr;
        end
      end else begin
        m_done = nd;
        if (nd == 3'b111) m_ist = 0;
      end
    end
    @(negedge clk);
  endtask
  task automatic ret(input logic [3:0] tx);
    mem_rtrn_vld = 1; mem_rtrn_txid = tx;
    step();
    mem_rtrn_vld = 0;
  endtask
  initial begin
    int rc;
    rst = 1; stall = 0; mem_ack = 0; mem_rtrn_vld = 0; inval_valid = 0;
    cl_req = 0; cl_we = 0; cl_txid = 0; cl_inval_ready = 0;
    mem_rtrn_txid = 0; inval_addr = 0;
    rnd_payload();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst = 0;
    step();
    // two clients streaming with ack held high
    cl_req = 3'b011; mem_ack = 1; cl_we = 3'b010; cl_txid = 6'b00_10_01;
    for (int i = 0; i < 6; i++) begin rnd_payload(); step(); end
    rst = 1; cl_req = 0; step(); rst = 0;
    // outstanding limit on client 0, then one return frees a slot
    cl_req = 3'b001;
    for (int i = 0; i < 6; i++) begin cl_txid = 6'(i); rnd_payload(); step(); end
    chk("limit_ack", cl_ack, 3'b000);
    ret(4'b0010);
    step();
    rst = 1; cl_req = 0; step(); rst = 0;
    // grant and return for client 1 in the same cycle
    cl_req = 3'b010; step();
    ret(4'b0100);
    cl_req = 0;
    ret(4'b0101);
    ret(4'b0110);
    step(); step();
    // stall with a held buffer
    mem_ack = 0; cl_req = 3'b001; step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin rnd_payload(); step(); end
    mem_ack = 1; step(); step();
    stall = 0; cl_req = 0;
    ret(4'b0000);
    step();
    // invalidation broadcast to three clients
    inval_valid = 1; inval_addr = 64'h8000_1000; step();
    inval_valid = 0;
    cl_inval_ready = 3'b001; step();
    cl_inval_ready = 3'b100; step();
    cl_inval_ready = 3'b010; step();
    cl_inval_ready = 0; step();
    // reset with work in flight, then a late return
    cl_req = 3'b011; mem_ack = 1; step(); step();
    mem_ack = 0; step();
    rst = 1; step();
    rst = 0; cl_req = 0;
    ret(4'b0111);
    chk("late_rtrn", cl_rtrn_vld, 3'b000);
    // random traffic
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(63) == 0);
      stall = ($urandom_range(7) == 0);
      mem_ack = ($urandom_range(3) != 0);
      cl_req = 3'($urandom);
      cl_we = 3'($urandom);
      cl_txid = 6'($urandom);
      rnd_payload();
      rc = $urandom_range(3);
      mem_rtrn_vld = 1'($urandom_range(1));
      mem_rtrn_txid = {2'(rc), 2'($urandom)};
      inval_valid = !m_ist && $urandom_range(5) == 0;
      inval_addr = {$urandom, $urandom};
      cl_inval_ready = 3'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
